// File: rtl/fm_stream_checker_if.sv
// Bus bundle for the FM/AGC stream checker: DUT sample lanes, the
// expected-sample fetch port and the run status/result signals.
interface fm_stream_checker_if #(
  parameter int DATA_W = 13,
  parameter int NUM_CH = 1,
  parameter int ADDR_W = 17,
  parameter int ERR_W  = 16
);
  logic                       clk_enable;
  logic                       start;
  logic [NUM_CH*DATA_W-1:0]   act_data;
  logic [NUM_CH*DATA_W-1:0]   exp_data;
  logic                       exp_rd;
  logic [ADDR_W-1:0]          exp_addr;
  logic                       busy;
  logic                       done;
  logic                       pass;
  logic [ERR_W-1:0]           err_count;
  logic [ADDR_W-1:0]          first_err_addr;
  logic [NUM_CH-1:0]          err_lane_mask;

  // Checker side
  modport slave (
    input  clk_enable, start, act_data, exp_data,
    output exp_rd, exp_addr, busy, done, pass, err_count, first_err_addr, err_lane_mask
  );

  // Environment side: drives samples/strobes, serves expected data, reads results
  modport master (
    output clk_enable, start, act_data, exp_data,
    input  exp_rd, exp_addr, busy, done, pass, err_count, first_err_addr, err_lane_mask
  );
endinterface

// File: rtl/fm_stream_checker.sv
// Hardware output checker for the AGC/FM datapath. Compares NUM_CH lanes of
// DUT output against an expected-sample stream fetched by address, with a
// per-lane tolerance, after skipping a fixed number of enabled cycles.
// Reports pass/fail, a saturating mismatch count, the first failing address
// and a sticky mask of failing lanes.
module fm_stream_checker #(
  parameter int DATA_W      = 13,
  parameter int NUM_CH      = 1,
  parameter int NUM_SAMPLES = 100000,
  parameter int ADDR_W      = 17,
  parameter int LATENCY     = 1,
  parameter int SIGNED_CMP  = 0,
  parameter int TOL         = 0,
  parameter int ERR_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input logic                 clk,
  input logic                 reset,
  fm_stream_checker_if.slave  bus
);

  localparam int LANE_W = DATA_W + 1;
  localparam int SKIP_W = $clog2(LATENCY + 1) + 1;
  localparam logic [ADDR_W-1:0] ADDR_END  = ADDR_W'(NUM_SAMPLES);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [LANE_W-1:0] TOL_MAG   = LANE_W'(TOL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ALIGN = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic                     run_start;
  logic                     fetch;
  logic                     cmp_take;
  logic                     cmp_last;
  logic                     sample_fail;
  logic [NUM_CH-1:0]        lane_fails;

  logic [ADDR_W-1:0]        exp_addr;
  logic [SKIP_W-1:0]        skip_cnt;
  logic [ERR_W-1:0]         err_count;
  logic [ADDR_W-1:0]        first_err_addr;
  logic [NUM_CH-1:0]        err_lane_mask;

  logic                     vld_p0;
  logic [NUM_CH*DATA_W-1:0] act_p0;
  logic [ADDR_W-1:0]        addr_p0;

  logic                     busy;
  logic                     done;
  logic                     pass;

  // |act - exp| > TOL, evaluated one bit wider than the lane so the
  // difference can never wrap in either signed or unsigned mode.
  function automatic logic lane_fail(input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] e);
    logic signed [LANE_W-1:0] ax;
    logic signed [LANE_W-1:0] ex;
    logic signed [LANE_W-1:0] d;
    logic        [LANE_W-1:0] mag;
    ax  = (SIGNED_CMP != 0) ? {a[DATA_W-1], a} : {1'b0, a};
    ex  = (SIGNED_CMP != 0) ? {e[DATA_W-1], e} : {1'b0, e};
    d   = ax - ex;
    mag = d[LANE_W-1] ? $unsigned(-d) : $unsigned(d);
    return (mag > TOL_MAG);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  // Start is only honoured between runs; a start while busy is dropped.
  assign run_start = bus.start && (state == S_IDLE || state == S_DONE);

  // A fetch is one expected-sample read; the address never goes past the end.
  assign fetch    = bus.clk_enable && (state == S_CHECK) && (exp_addr < ADDR_END);

  // Stage p1: compare the registered DUT sample with the returned expected data
  assign cmp_take = bus.clk_enable && vld_p0 && (state == S_CHECK);
  assign cmp_last = (addr_p0 == ADDR_LAST);

  // Per-lane tolerance check on the in-flight sample
  always_comb begin
    lane_fails = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      lane_fails[k] = lane_fail(act_p0[k*DATA_W +: DATA_W], bus.exp_data[k*DATA_W +: DATA_W]);
    end
  end

  assign sample_fail = |lane_fails;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: the run ends on the compare of the last address (or the
  // first mismatch when stopping on error), so that result is always counted.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_nxt = (LATENCY == 0) ? S_CHECK : S_ALIGN;
        end
      end
      S_ALIGN: begin
        if (bus.clk_enable && (skip_cnt == SKIP_LAST)) begin
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cmp_take && (cmp_last || ((STOP_ON_ERR != 0) && sample_fail))) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    busy = (state == S_ALIGN) || (state == S_CHECK);
    done = (state == S_DONE);
    pass = done && (err_count == '0);
  end

  // Stage p0: run control, fetch address, compare-valid tag and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_addr       <= '0;
      skip_cnt       <= '0;
      vld_p0         <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      err_lane_mask  <= '0;
    end else if (run_start) begin
      exp_addr       <= '0;
      skip_cnt       <= '0;
      vld_p0         <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      err_lane_mask  <= '0;
    end else begin
      if ((state == S_ALIGN) && bus.clk_enable) begin
        skip_cnt <= skip_cnt + SKIP_W'(1);
      end
      if (fetch) begin
        exp_addr <= exp_addr + ADDR_W'(1);
      end
      if (bus.clk_enable) begin
        vld_p0 <= fetch;
      end
      if (cmp_take && sample_fail) begin
        err_count     <= sat_inc(err_count);
        err_lane_mask <= err_lane_mask | lane_fails;
        if (err_count == '0) begin
          first_err_addr <= addr_p0;
        end
      end
    end
  end

  // Stage p0: capture the DUT sample and its address alongside each fetch
  always_ff @(posedge clk) begin
    if (fetch) begin
      act_p0  <= bus.act_data;
      addr_p0 <= exp_addr;
    end
  end

  assign bus.exp_rd         = fetch;
  assign bus.exp_addr       = exp_addr;
  assign bus.busy           = busy;
  assign bus.done           = done;
  assign bus.pass           = pass;
  assign bus.err_count      = err_count;
  assign bus.first_err_addr = first_err_addr;
  assign bus.err_lane_mask  = err_lane_mask;

endmodule

// File: tb/tb_fm_stream_checker.sv
// Directed bench for fm_stream_checker: four checker instances with
// different parameter sets, each fed by a small expected-data ROM model.
module tb_fm_stream_checker;

  logic clk;
  logic reset;

  int n_tests;
  int n_fail;

  logic [12:0] tab1 [16];
  logic [25:0] rom3 [4];
  logic [25:0] act3 [4];

  fm_stream_checker_if #(.DATA_W(13), .NUM_CH(1), .ADDR_W(5), .ERR_W(16)) b1 ();
  fm_stream_checker_if #(.DATA_W(13), .NUM_CH(2), .ADDR_W(2), .ERR_W(16)) b3 ();
  fm_stream_checker_if #(.DATA_W(13), .NUM_CH(1), .ADDR_W(4), .ERR_W(2))  b4 ();
  fm_stream_checker_if #(.DATA_W(13), .NUM_CH(1), .ADDR_W(4), .ERR_W(2))  b5 ();

  fm_stream_checker #(.DATA_W(13), .NUM_CH(1), .NUM_SAMPLES(16), .ADDR_W(5), .LATENCY(1),
                      .SIGNED_CMP(0), .TOL(0), .ERR_W(16), .STOP_ON_ERR(0))
    u1 (.clk(clk), .reset(reset), .bus(b1.slave));

  fm_stream_checker #(.DATA_W(13), .NUM_CH(2), .NUM_SAMPLES(3), .ADDR_W(2), .LATENCY(0),
                      .SIGNED_CMP(1), .TOL(2), .ERR_W(16), .STOP_ON_ERR(0))
    u3 (.clk(clk), .reset(reset), .bus(b3.slave));

  fm_stream_checker #(.DATA_W(13), .NUM_CH(1), .NUM_SAMPLES(8), .ADDR_W(4), .LATENCY(1),
                      .SIGNED_CMP(0), .TOL(0), .ERR_W(2), .STOP_ON_ERR(0))
    u4 (.clk(clk), .reset(reset), .bus(b4.slave));

  fm_stream_checker #(.DATA_W(13), .NUM_CH(1), .NUM_SAMPLES(8), .ADDR_W(4), .LATENCY(1),
                      .SIGNED_CMP(0), .TOL(0), .ERR_W(2), .STOP_ON_ERR(1))
    u5 (.clk(clk), .reset(reset), .bus(b5.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected-sample sources: registered read, data valid one cycle after exp_rd
  always @(posedge clk) if (b1.exp_rd) b1.exp_data <= tab1[b1.exp_addr[3:0]];
  always @(posedge clk) if (b3.exp_rd) b3.exp_data <= rom3[b3.exp_addr];
  always @(posedge clk) if (b4.exp_rd) b4.exp_data <= 13'(b4.exp_addr);
  always @(posedge clk) if (b5.exp_rd) b5.exp_data <= 13'(b5.exp_addr);

  function automatic logic [25:0] pk(input int l0, input int l1);
    return {13'(l1), 13'(l0)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Run instance 1; the DUT stream is the expected stream shifted by LATENCY.
  task automatic run1(input int bad, input bit rnd, input bit spam, input int max_en,
                      output int e, output bit to);
    int  ncyc;
    int  idx;
    bit  en;
    e = 0; ncyc = 0; to = 1'b0;
    b1.clk_enable = 1'b1;
    b1.start = 1'b1;
    @(posedge clk); #1;
    b1.start = 1'b0;
    while (!b1.done && e < max_en) begin
      if (ncyc >= 400) begin
        to = 1'b1;
        break;
      end
      en  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      idx = e - 1;
      b1.clk_enable = en;
      b1.act_data = (idx >= 0 && idx < 16) ? tab1[idx] + ((idx == bad) ? 13'd1 : 13'd0) : 13'd0;
      b1.start = spam && (ncyc % 4 == 1);
      @(posedge clk); #1;
      if (en) e++;
      ncyc++;
    end
    b1.start = 1'b0;
    b1.clk_enable = 1'b0;
  endtask

  // Run instance 3 (LATENCY 0, two signed lanes)
  task automatic run3(output int e, output bit to);
    int ncyc;
    e = 0; ncyc = 0; to = 1'b0;
    b3.clk_enable = 1'b1;
    b3.start = 1'b1;
    @(posedge clk); #1;
    b3.start = 1'b0;
    while (!b3.done) begin
      if (ncyc >= 400) begin
        to = 1'b1;
        break;
      end
      b3.act_data = (e < 4) ? act3[e] : 26'd0;
      @(posedge clk); #1;
      e++;
      ncyc++;
    end
    b3.clk_enable = 1'b0;
  endtask

  // Run instance 4 or 5 with every sample off by 100
  task automatic run45(input bit which, output int e, output bit to);
    int ncyc;
    e = 0; ncyc = 0; to = 1'b0;
    if (which) begin b5.clk_enable = 1'b1; b5.start = 1'b1; end
    else       begin b4.clk_enable = 1'b1; b4.start = 1'b1; end
    @(posedge clk); #1;
    b4.start = 1'b0;
    b5.start = 1'b0;
    while (!(which ? b5.done : b4.done)) begin
      if (ncyc >= 400) begin
        to = 1'b1;
        break;
      end
      if (which) b5.act_data = 13'(e - 1 + 100);
      else       b4.act_data = 13'(e - 1 + 100);
      @(posedge clk); #1;
      e++;
      ncyc++;
    end
    b4.clk_enable = 1'b0;
    b5.clk_enable = 1'b0;
  endtask

  initial begin
    int  ne;
    bit  to;
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 16; i++) tab1[i] = 13'(i * 517 + 100);
    rom3[0] = pk(-4, -1); act3[0] = pk(-2, 1);
    rom3[1] = pk(-4, 7);  act3[1] = pk(-7, 7);
    rom3[2] = pk(-4, 7);  act3[2] = pk(-4, 5);
    rom3[3] = 26'd0;      act3[3] = 26'd0;

    reset = 1'b1;
    b1.clk_enable = 0; b1.start = 0; b1.act_data = '0;
    b3.clk_enable = 0; b3.start = 0; b3.act_data = '0;
    b4.clk_enable = 0; b4.start = 0; b4.act_data = '0;
    b5.clk_enable = 0; b5.start = 0; b5.act_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_done", 32'(b1.done), 0);
    chk("rst_busy", 32'(b1.busy), 0);
    chk("rst_pass", 32'(b1.pass), 0);
    chk("rst_addr", 32'(b1.exp_addr), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: clean run
    run1(-1, 1'b0, 1'b0, 1000, ne, to);
    chk("t1_timeout", 32'(to), 0);
    chk("t1_en_cycles", 32'(ne), 18);
    chk("t1_pass", 32'(b1.pass), 1);
    chk("t1_err", 32'(b1.err_count), 0);
    chk("t1_addr_end", 32'(b1.exp_addr), 16);
    chk("t1_busy", 32'(b1.busy), 0);

    // 2: sample 5 off by one, re-run from DONE
    run1(5, 1'b0, 1'b0, 1000, ne, to);
    chk("t2_en_cycles", 32'(ne), 18);
    chk("t2_err", 32'(b1.err_count), 1);
    chk("t2_first", 32'(b1.first_err_addr), 5);
    chk("t2_mask", 32'(b1.err_lane_mask), 1);
    chk("t2_pass", 32'(b1.pass), 0);

    // 3: signed lanes with tolerance 2
    run3(ne, to);
    chk("t3_timeout", 32'(to), 0);
    chk("t3_en_cycles", 32'(ne), 4);
    chk("t3_err", 32'(b3.err_count), 1);
    chk("t3_first", 32'(b3.first_err_addr), 1);
    chk("t3_mask", 32'(b3.err_lane_mask), 1);
    chk("t3_pass", 32'(b3.pass), 0);
    act3[2] = pk(-4, 4);
    run3(ne, to);
    chk("t3b_err", 32'(b3.err_count), 2);
    chk("t3b_first", 32'(b3.first_err_addr), 1);
    chk("t3b_mask", 32'(b3.err_lane_mask), 3);

    // 4: saturating counter, then stop on first error
    run45(1'b0, ne, to);
    chk("t4_timeout", 32'(to), 0);
    chk("t4_en_cycles", 32'(ne), 10);
    chk("t4_err_sat", 32'(b4.err_count), 3);
    chk("t4_first", 32'(b4.first_err_addr), 0);
    chk("t4_pass", 32'(b4.pass), 0);
    run45(1'b1, ne, to);
    chk("t4s_timeout", 32'(to), 0);
    chk("t4s_en_cycles", 32'(ne), 3);
    chk("t4s_done", 32'(b5.done), 1);
    chk("t4s_err", 32'(b5.err_count), 1);
    chk("t4s_first", 32'(b5.first_err_addr), 0);

    // 5: random enable with start pulses while busy
    run1(-1, 1'b1, 1'b1, 1000, ne, to);
    chk("t5_timeout", 32'(to), 0);
    chk("t5_en_cycles", 32'(ne), 18);
    chk("t5_pass", 32'(b1.pass), 1);
    chk("t5_err", 32'(b1.err_count), 0);
    chk("t5_addr_end", 32'(b1.exp_addr), 16);

    // 6: reset part-way through a failing run, then a clean re-run
    run1(3, 1'b0, 1'b0, 10, ne, to);
    chk("t6_busy_mid", 32'(b1.busy), 1);
    chk("t6_err_mid", 32'(b1.err_count), 1);
    chk("t6_addr_mid", 32'(b1.exp_addr), 9);
    reset = 1'b1;
    #1;
    chk("t6_rst_busy", 32'(b1.busy), 0);
    chk("t6_rst_err", 32'(b1.err_count), 0);
    chk("t6_rst_first", 32'(b1.first_err_addr), 0);
    chk("t6_rst_mask", 32'(b1.err_lane_mask), 0);
    chk("t6_rst_addr", 32'(b1.exp_addr), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("t6_idle_done", 32'(b1.done), 0);
    run1(-1, 1'b0, 1'b0, 1000, ne, to);
    chk("t6_en_cycles", 32'(ne), 18);
    chk("t6_pass", 32'(b1.pass), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
